mips_instr_encoder: RTL and testbench

Sequential encoder that produces the 32-bit MIPS instruction words consumed by the control-unit decode path. It accepts symbolic instructions over a valid/ready stream, encodes op/rs/rt/rd/shamt/funct/imm/target fields and writes them to consecutive instruction-memory words. On a finish request it appends a self-jump halt word. It serves as the program loader for single-cycle bring-up and self-checking benches.

---
 rtl/mips_instr_encoder_pkg.sv | 48 ++++
 rtl/mips_instr_encoder_if.sv | 33 +++
 rtl/mips_instr_encoder_field_pack.sv | 61 ++++++
 rtl/mips_instr_encoder.sv | 120 ++++++++++++
 tb/tb_mips_instr_encoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// Shared types and encoding constants for the MIPS instruction encoder.
package mips_enc_pkg;

    // Symbolic instruction kinds accepted on the request stream; 13-15 are illegal.
    typedef enum logic [3:0] {
        KIND_ADD  = 4'd0,
        KIND_SUB  = 4'd1,
        KIND_AND  = 4'd2,
        KIND_OR   = 4'd3,
        KIND_SLT  = 4'd4,
        KIND_SLLV = 4'd5,
        KIND_LW   = 4'd6,
        KIND_SW   = 4'd7,
        KIND_BEQ  = 4'd8,
        KIND_ADDI = 4'd9,
        KIND_J    = 4'd10,
        KIND_LUI  = 4'd11,
        KIND_LB   = 4'd12
    } instr_kind_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_t;

    // J-type word.
    function automatic logic [31:0] enc_jump(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request stream, imem write port and status of the instruction encoder.
interface mips_instr_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              finish;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic              done;

    // Driver side: issues requests, observes the write port and status.
    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, finish,
        input  in_ready, wr_en, wr_addr, wr_data, count, full, err, done
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, finish,
        output in_ready, wr_en, wr_addr, wr_data, count, full, err, done
    );
endinterface

// File: rtl/mips_instr_encoder_field_pack.sv
// Combinational field packer: symbolic kind + operand fields -> 32-bit word.
// Optional ENC_REGCHECK_EN rejects register-writing kinds whose destination is $0.
module mips_field_pack
    import mips_enc_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);
    instr_kind_t k;
    logic        bad_kind;

    assign k = instr_kind_t'(kind);

    // Select the instruction format for each kind; unknown kinds are flagged.
    always_comb begin
        word     = '0;
        bad_kind = 1'b0;
        case (k)
            KIND_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            KIND_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            KIND_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            KIND_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            KIND_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            KIND_SLLV: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLLV};
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            KIND_J:    word = enc_jump(target);
            KIND_LUI:  word = {OP_LUI, 5'd0, rt, imm};
            KIND_LB:   word = {OP_LB, rs, rt, imm};
            default:   bad_kind = 1'b1;
        endcase
    end

`ifdef ENC_REGCHECK_EN
    logic dest_zero;

    // Destination is rd for R-type, rt for immediate-form register writers.
    always_comb begin
        dest_zero = 1'b0;
        case (k)
            KIND_ADD, KIND_SUB, KIND_AND, KIND_OR, KIND_SLT, KIND_SLLV:
                dest_zero = (rd == 5'd0);
            KIND_LW, KIND_ADDI, KIND_LUI, KIND_LB:
                dest_zero = (rt == 5'd0);
            default: dest_zero = 1'b0;
        endcase
    end

    assign illegal = bad_kind | dest_zero;
`else
    assign illegal = bad_kind;
`endif
endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential MIPS program loader: encodes requests into consecutive imem words and
// appends a self-jump halt word on finish. Optional feature macro: ENC_REGCHECK_EN.
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_WORD = 0
) (
    input logic                 clk,
    input logic                 reset,
    mips_instr_encoder_if.slave bus
);
    localparam int unsigned CW = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              halt_pend_q, halt_pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        full;
    logic        ready;
    logic        hs;
    logic [25:0] halt_target;

    mips_field_pack u_pack (
        .kind    (bus.in_kind),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // count never exceeds 2**ADDR_W, so its top bit is exactly the full flag.
    assign full        = count_q[ADDR_W];
    assign ready       = (state_q == RUN) && !full && !halt_pend_q;
    assign hs          = bus.in_valid && ready;
    assign halt_target = 26'(BASE_WORD) + 26'(count_q);

    // Next-state: accept/encode requests, schedule and emit the halt word.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        halt_pend_d = halt_pend_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        unique case (state_q)
            RUN: begin
                if (hs) begin
                    if (packed_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q[ADDR_W-1:0];
                        wr_data_d = packed_word;
                        count_d   = count_q + CW'(1);
                    end
                    // Instruction goes first; the halt follows once the stream is quiet.
                    if (bus.finish) halt_pend_d = 1'b1;
                end else if (bus.finish || halt_pend_q) begin
                    halt_pend_d = 1'b0;
                    if (full) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q[ADDR_W-1:0];
                wr_data_d = enc_jump(halt_target);
                count_d   = count_q + CW'(1);
                state_d   = DONE;
            end
            DONE: ;
            default: state_d = DONE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            count_q     <= '0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            halt_pend_q <= halt_pend_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.err      = err_q;
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: directed vectors push expected
// {addr, word} pairs; a negedge monitor pops and compares on every wr_en.
module tb_mips_instr_encoder;
    import mips_enc_pkg::*;

    localparam int unsigned ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   exp_addr = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_WORD(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: every write must match the next expected word, in order.
    always @(negedge clk) begin
        if (!reset && bus.wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             bus.wr_addr, bus.wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.finish   = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_addr = 0;
        reset    = 1'b0;
    endtask

    // Present one request at a negedge; it is taken at the next rising edge with ready.
    task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic fin,
                        input logic push, input logic [31:0] word);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_kind   = kind;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.finish    = fin;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0, required 1 within 50 cycles");
        end else if (push) begin
            exp_q.push_back('{addr: ADDR_W'(exp_addr), data: word});
            exp_addr++;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.finish   = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_kind   = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_rd     = '0;
        bus.in_imm    = '0;
        bus.in_target = '0;
        bus.finish    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_data", bus.wr_data, 0);
        do_reset();
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // Single R-type, then back-to-back I-types, then LUI/SLLV.
        send(KIND_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820);
        idle();
        check("add_count", 32'(bus.count), 1);
        send(KIND_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0, 1'b1, 32'h8FA80004);
        send(KIND_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h1022FFFF);
        idle();
        check("beq_no_bubble_wr_en", 32'(bus.wr_en), 1);
        check("beq_wr_addr", 32'(bus.wr_addr), 2);
        check("burst_count", 32'(bus.count), 3);
        send(KIND_LUI, 5'd9, 5'd5, 5'd0, 16'h1234, 26'h0, 1'b0, 1'b1, 32'h3C051234);
        send(KIND_SLLV, 5'd6, 5'd7, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00C72004);
        idle();
        check("lui_sllv_count", 32'(bus.count), 5);
        @(negedge clk);
        check("hold_wr_en", 32'(bus.wr_en), 0);
        check("hold_wr_data", bus.wr_data, 32'h00C72004);

        // Finish coincident with the 4th handshake: instruction first, then halt.
        do_reset();
        send(KIND_SUB, 5'd10, 5'd11, 5'd9, 16'h0, 26'h0, 1'b0, 1'b1, 32'h014B4822);
        send(KIND_AND, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00430824);
        send(KIND_OR, 5'd31, 5'd0, 5'd31, 16'h0, 26'h0, 1'b0, 1'b1, 32'h03E0F825);
        send(KIND_SLT, 5'd4, 5'd5, 5'd8, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0085402A);
        exp_q.push_back('{addr: ADDR_W'(4), data: 32'h08000004});
        idle();
        wait_done();
        @(negedge clk);
        check("halt_done", 32'(bus.done), 1);
        check("halt_in_ready", 32'(bus.in_ready), 0);
        check("halt_count", 32'(bus.count), 5);
        check("halt_err", 32'(bus.err), 0);
        check("halt_queue_drained", 32'(exp_q.size()), 0);

        // Remaining formats and the $0-destination case.
        do_reset();
        send(KIND_SW, 5'd29, 5'd9, 5'd0, 16'h0008, 26'h0, 1'b0, 1'b1, 32'hAFA90008);
        send(KIND_LB, 5'd4, 5'd2, 5'd0, 16'hFFFC, 26'h0, 1'b0, 1'b1, 32'h8082FFFC);
        send(KIND_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b0, 1'b1, 32'h08000010);
`ifdef ENC_REGCHECK_EN
        send(KIND_ADDI, 5'd3, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        check("regcheck_err", 32'(bus.err), 1);
        check("regcheck_count", 32'(bus.count), 3);
`else
        send(KIND_ADDI, 5'd3, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0, 1'b1, 32'h20600005);
        idle();
        @(negedge clk);
        check("addi_r0_err", 32'(bus.err), 0);
        check("addi_r0_count", 32'(bus.count), 4);
`endif

        // Illegal kind: accepted, no write, sticky error.
        do_reset();
        send(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        check("illegal_err", 32'(bus.err), 1);
        check("illegal_count", 32'(bus.count), 0);
        check("illegal_in_ready", 32'(bus.in_ready), 1);

        // Fill every slot, then finish while full.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            send(KIND_ADDI, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0, 1'b0, 1'b1,
                 32'h20010000 | 32'(i));
        end
        idle();
        check("fill_full", 32'(bus.full), 1);
        check("fill_in_ready", 32'(bus.in_ready), 0);
        check("fill_count", 32'(bus.count), 64);
        bus.finish = 1'b1;
        @(negedge clk);
        bus.finish = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        check("full_finish_done", 32'(bus.done), 1);
        check("full_finish_err", 32'(bus.err), 1);
        check("full_finish_count", 32'(bus.count), 64);
        check("final_queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
